// File: rtl/stms_1.sv
// Four-way traffic signal sequencer: round-robin service of demanded
// approaches with timed green/yellow and emergency/priority pre-emption.
module stms_1 (
    input  logic       clk,
    input  logic       rst,
    input  logic       alert1,
    input  logic       alert2,
    input  logic       emrg,
    input  logic       sensor_north,
    input  logic       sensor_east,
    input  logic       sensor_south,
    input  logic       sensor_west,
    output logic [2:0] NS,
    output logic [2:0] NW,
    output logic [2:0] EW,
    output logic [2:0] EN,
    output logic [2:0] SN,
    output logic [2:0] SE,
    output logic [2:0] WE,
    output logic [2:0] WS,
    output logic       ambulance,
    output logic       police,
    output logic [4:0] count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GREEN,
        S_YELLOW,
        S_EMRG,
        S_PRE
    } state_t;

    localparam logic [2:0] C_RED = 3'b100;
    localparam logic [2:0] C_YEL = 3'b010;
    localparam logic [2:0] C_GRN = 3'b001;
    localparam logic [1:0] A_W   = 2'd3;

    state_t           state_q, state_d;
    logic [1:0]       app_q, app_d;
    logic [1:0]       last_q, last_d;
    logic [4:0]       count_q, count_d;
    logic [3:0][2:0]  col_q, col_d;
    logic             amb_q, amb_d;
    logic             pol_q, pol_d;
    logic [3:0]       sens;
    logic [2:0]       sel_last;
    logic [2:0]       sel_app;

    assign sens = {sensor_west, sensor_south, sensor_east, sensor_north};

    // Returns {found, approach}; the search begins just after 'from'
    // and wraps so that 'from' itself is considered last.
    function automatic logic [2:0] pick(input logic [1:0] from,
                                        input logic [3:0] s);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = from + k[1:0];
            if (s[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    assign sel_last = pick(last_q, sens);
    assign sel_app  = pick(app_q, sens);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            app_q   <= A_W;
            last_q  <= A_W;
            count_q <= 5'd0;
            col_q   <= {4{C_RED}};
            amb_q   <= 1'b0;
            pol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            app_q   <= app_d;
            last_q  <= last_d;
            count_q <= count_d;
            col_q   <= col_d;
            amb_q   <= amb_d;
            pol_q   <= pol_d;
        end
    end

    always_comb begin
        state_d = state_q;
        app_d   = app_q;
        last_d  = last_q;
        count_d = count_q;
        if (emrg || alert1 || alert2) begin
            state_d = emrg ? S_EMRG : S_PRE;
            count_d = 5'd0;
            if (state_q == S_GREEN || state_q == S_YELLOW) last_d = app_q;
        end else begin
            unique case (state_q)
                S_GREEN: begin
                    if (count_q == 5'd0) begin
                        state_d = S_YELLOW;
                        count_d = 5'd4;
                    end else begin
                        count_d = count_q - 5'd1;
                    end
                end
                S_YELLOW: begin
                    if (count_q == 5'd0) begin
                        last_d = app_q;
                        if (sel_app[2]) begin
                            state_d = S_GREEN;
                            app_d   = sel_app[1:0];
                            count_d = 5'd19;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        count_d = count_q - 5'd1;
                    end
                end
                default: begin
                    if (sel_last[2]) begin
                        state_d = S_GREEN;
                        app_d   = sel_last[1:0];
                        count_d = 5'd19;
                    end else begin
                        state_d = S_IDLE;
                        count_d = 5'd0;
                    end
                end
            endcase
        end
    end

    // Lights are decoded from the next state so they register alongside it.
    always_comb begin
        col_d = {4{C_RED}};
        amb_d = 1'b0;
        pol_d = 1'b0;
        unique case (state_d)
            S_GREEN:  col_d[app_d] = C_GRN;
            S_YELLOW: col_d[app_d] = C_YEL;
            S_PRE: begin
                amb_d = alert1;
                pol_d = alert2;
            end
            default: ;
        endcase
    end

    assign NS        = col_q[0];
    assign NW        = col_q[0];
    assign EW        = col_q[1];
    assign EN        = col_q[1];
    assign SN        = col_q[2];
    assign SE        = col_q[2];
    assign WE        = col_q[3];
    assign WS        = col_q[3];
    assign ambulance = amb_q;
    assign police    = pol_q;
    assign count     = count_q;

endmodule

// File: tb/tb_stms_1.sv
// Randomized scoreboard bench for stms_1 against a phase-time
// reference model of the intersection.
module tb_stms_1;

    logic       clk;
    logic       rst, alert1, alert2, emrg;
    logic       sn, se, ss, sw;
    logic [2:0] NS, NW, EW, EN, SN, SE, WE, WS;
    logic       ambulance, police;
    logic [4:0] count;

    stms_1 dut (
        .clk(clk), .rst(rst), .alert1(alert1), .alert2(alert2),
        .emrg(emrg), .sensor_north(sn), .sensor_east(se),
        .sensor_south(ss), .sensor_west(sw),
        .NS(NS), .NW(NW), .EW(EW), .EN(EN),
        .SN(SN), .SE(SE), .WE(WE), .WS(WS),
        .ambulance(ambulance), .police(police), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] lights;
        logic [4:0]  cnt;
        logic        amb;
        logic        pol;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // Model: mode, served approach, and time elapsed within the phase.
    localparam int M_IDLE = 0, M_SERVE = 1, M_EMRG = 2, M_PRE = 3;
    int m_mode, m_app, m_t, m_last;
    bit m_amb, m_pol;

    task automatic model_step();
        logic [3:0] s;
        int found;
        s = {sw, ss, se, sn};
        m_amb = 0;
        m_pol = 0;
        if (!rst) begin
            m_mode = M_IDLE;
            m_last = 3;
            m_t = 0;
        end else if (emrg || alert1 || alert2) begin
            if (m_mode == M_SERVE) m_last = m_app;
            m_mode = emrg ? M_EMRG : M_PRE;
            if (!emrg) begin
                m_amb = alert1;
                m_pol = alert2;
            end
        end else if (m_mode == M_SERVE && m_t < 24) begin
            m_t++;
        end else begin
            if (m_mode == M_SERVE) m_last = m_app;
            found = -1;
            for (int k = 1; k <= 4 && found < 0; k++)
                if (s[(m_last + k) % 4]) found = (m_last + k) % 4;
            if (found >= 0) begin
                m_mode = M_SERVE;
                m_app = found;
                m_t = 0;
            end else begin
                m_mode = M_IDLE;
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        logic [2:0] c;
        e.lights = '0;
        for (int a = 0; a < 4; a++) begin
            c = 3'b100;
            if (m_mode == M_SERVE && m_app == a)
                c = (m_t < 20) ? 3'b001 : 3'b010;
            e.lights[6*a +: 6] = {c, c};
        end
        e.cnt = 5'd0;
        if (m_mode == M_SERVE)
            e.cnt = (m_t < 20) ? 5'(19 - m_t) : 5'(24 - m_t);
        e.amb = m_amb;
        e.pol = m_pol;
        return e;
    endfunction

    task automatic drive(input bit r, input bit e, input bit a1,
                         input bit a2, input logic [3:0] s);
        @(negedge clk);
        rst = r;
        emrg = e;
        alert1 = a1;
        alert2 = a2;
        {sw, ss, se, sn} = s;
        model_step();
        sbq.push_back(model_out());
    endtask

    task automatic bound_fail(input string what);
        checks++;
        errors++;
        $display("FAIL wait_%s: condition not reached, got timeout, need event", what);
    endtask

    // Monitor: every cycle the DUT presents a new registered output.
    initial begin
        exp_t e;
        logic [23:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                act = {WS, WE, SE, SN, EN, EW, NW, NS};
                checks++;
                if (act !== e.lights) begin
                    errors++;
                    $display("FAIL lights t=%0t: got %h need %h", $time, act, e.lights);
                end
                checks++;
                if (count !== e.cnt) begin
                    errors++;
                    $display("FAIL count t=%0t: got %0d need %0d", $time, count, e.cnt);
                end
                checks++;
                if ({ambulance, police} !== {e.amb, e.pol}) begin
                    errors++;
                    $display("FAIL amb_pol t=%0t: got %b%b need %b%b", $time,
                             ambulance, police, e.amb, e.pol);
                end
            end
        end
    end

    initial begin
        int i;
        logic [3:0] s;
        bit e, a1, a2, r;
        rst = 0; emrg = 0; alert1 = 0; alert2 = 0;
        sn = 0; se = 0; ss = 0; sw = 0;
        m_mode = M_IDLE; m_app = 0; m_t = 0; m_last = 3;
        m_amb = 0; m_pol = 0;

        repeat (2) drive(0, 0, 0, 0, 4'hF);
        repeat (210) drive(1, 0, 0, 0, 4'hF);
        repeat (110) drive(1, 0, 0, 0, 4'b1100);
        repeat (40) drive(1, 0, 0, 0, 4'b0000);
        repeat (3) drive(1, 0, 0, 0, 4'b0100);

        i = 0;
        while (i < 300 && !(m_mode == M_SERVE && m_app == 1 && m_t == 5)) begin
            drive(1, 0, 0, 0, 4'hF);
            i++;
        end
        if (i == 300) bound_fail("e_green");
        repeat (3) drive(1, 1, 0, 0, 4'hF);
        repeat (4) drive(1, 0, 0, 0, 4'hF);

        repeat (5) drive(1, 0, 1, 0, 4'hF);
        repeat (3) drive(1, 0, 1, 1, 4'hF);
        repeat (3) drive(1, 1, 1, 0, 4'hF);
        repeat (30) drive(1, 0, 0, 0, 4'hF);

        i = 0;
        while (i < 300 && !(m_mode == M_SERVE && m_app == 3 && m_t == 21)) begin
            drive(1, 0, 0, 0, 4'hF);
            i++;
        end
        if (i == 300) bound_fail("w_yellow");
        drive(0, 0, 0, 0, 4'hF);
        repeat (5) drive(1, 0, 0, 0, 4'hF);

        s = 4'hF;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 29) == 0) s = 4'($urandom);
            e  = ($urandom_range(0, 99) < 2);
            a1 = ($urandom_range(0, 99) < 2);
            a2 = ($urandom_range(0, 99) < 2);
            r  = ($urandom_range(0, 499) != 0);
            drive(r, e, a1, a2, s);
        end

        @(posedge clk);
        #2;
        if (sbq.size() != 0) bound_fail("drain");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
